// File: rtl/fib_seq_ctrl_pkg.sv
// Shared definitions for the fibonacci sequencer: state encoding and default widths.
package fib_seq_ctrl_pkg;

  localparam int FIB_WIDTH_DEF = 32;
  localparam int FIB_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fib_state_e;

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Request and term-stream handshake bundle between the sequencer and its client.
interface fib_seq_ctrl_if
  import fib_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int CNT_W = FIB_CNT_W_DEF
) ();

  // Both channels are strict valid/ready: a beat transfers on a rising clk edge
  // where valid and ready are both high; once raised, valid and its payload hold
  // until that transfer happens, and valid never waits on ready.
  logic             req_valid;
  logic [CNT_W-1:0] req_count;
  logic             req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output req_valid, req_count, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_count, out_ready,
    output req_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fib_term_counter.sv
// Remaining-term counter: loads the requested count, steps down once per accepted beat.
module fib_term_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_zero,
  output logic             is_last
);

  logic [CNT_W-1:0] remaining;

  // Saturates at zero so a stray decrement can never wrap to the maximum count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (dec && (remaining != '0)) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign is_zero = (remaining == '0);
  assign is_last = (remaining == CNT_W'(1));

endmodule

// File: rtl/fib_seq_ctrl.sv
// Sequencer for an external fibonacci engine: clears it, steps it per accepted beat.
// Optional wrap detection is built when FIB_SEQ_OVF_CHK_EN is defined.
module fib_seq_ctrl
  import fib_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int CNT_W = FIB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  fib_seq_ctrl_if.slave    bus,
  input  logic             abort,
  output logic             eng_clr,
  output logic             eng_on,
  input  logic [WIDTH-1:0] eng_value,
  output logic             done,
  output logic             busy,
  output logic             err_ovf,
  output fib_state_e       state_dbg
);

  fib_state_e state, state_nxt;
  logic       req_ready_c;
  logic       out_valid_c;
  logic       out_last_c;
  logic       accept;
  logic       cnt_load;
  logic       cnt_zero;
  logic       cnt_last;
  logic       wrap_hit;

  fib_term_counter #(.CNT_W(CNT_W)) u_term_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (bus.req_count),
    .dec      (accept),
    .is_zero  (cnt_zero),
    .is_last  (cnt_last)
  );

  assign accept = out_valid_c & bus.out_ready;

`ifdef FIB_SEQ_OVF_CHK_EN
  logic [WIDTH-1:0] prev;
  logic [1:0]       acc_seen;
  logic             err_q;

  // Wrap is only meaningful once two terms have gone out (F0=0, F1=1 never decrease).
  assign wrap_hit = (state == ST_RUN) && (acc_seen == 2'd2) && (eng_value < prev);
  assign err_ovf  = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      acc_seen <= 2'd0;
      err_q    <= 1'b0;
    end else if (cnt_load) begin
      acc_seen <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        prev <= eng_value;
        if (acc_seen != 2'd2) acc_seen <= acc_seen + 2'd1;
      end
      if (wrap_hit && !abort) err_q <= 1'b1;
    end
  end
`else
  assign wrap_hit = 1'b0;
  assign err_ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    eng_clr     = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    done        = 1'b0;
    cnt_load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          cnt_load  = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        eng_clr = 1'b1;
        if (abort || cnt_zero) state_nxt = ST_DONE;
        else                   state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A wrapped term is never offered; a beat accepted alongside abort still counts.
        out_valid_c = !wrap_hit;
        out_last_c  = !wrap_hit && cnt_last;
        if (abort || wrap_hit || (!wrap_hit && bus.out_ready && cnt_last))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign eng_on        = accept;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;
  assign bus.req_ready = req_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = eng_value;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl with an 8-bit fibonacci engine model and a term-level scoreboard.
module tb_fib_seq_ctrl;
  import fib_seq_ctrl_pkg::*;

  localparam int W        = 8;
  localparam int CW       = 16;
  localparam int TERM_MOD = 256;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       abort;
  logic       eng_clr, eng_on, done, busy, err_ovf;
  fib_state_e state_dbg;
  logic [W-1:0] eng_a = 8'd0;
  logic [W-1:0] eng_b = 8'd1;

  fib_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  fib_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .abort     (abort),
    .eng_clr   (eng_clr),
    .eng_on    (eng_on),
    .eng_value (eng_a),
    .done      (done),
    .busy      (busy),
    .err_ovf   (err_ovf),
    .state_dbg (state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external fibonacci engine
  always @(posedge clk) begin
    if (eng_clr) begin
      eng_a <= 8'd0;
      eng_b <= 8'd1;
    end else if (eng_on) begin
      eng_a <= eng_b;
      eng_b <= eng_a + eng_b;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // reference: k-th fibonacci term modulo the engine width
  function automatic int fib_term(input int k);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = (a + b) % TERM_MOD;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  bit           exp_last_q[$];
  int           got_q[$];
  int           acc_cyc_q[$];
  int done_cnt = 0, clr_cnt = 0, busy_cnt = 0;
  int done_cyc = 0, clr_cyc = 0, req_cyc = 0;
  bit stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      check("busy_vs_req_ready", busy, !bus.req_ready);
      check("eng_on", eng_on, bus.out_valid && bus.out_ready);
      if (bus.out_valid) check("out_data_passthru", bus.out_data, eng_a);
      else               check("out_last_unqualified", bus.out_last, 0);
      if (stall_prev) begin
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_data_held", bus.out_data, stall_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got data %0d expected no beat (cycle %0d)", bus.out_data, cyc);
        end else begin
          logic [W-1:0] d;
          bit l;
          d = exp_q.pop_front();
          l = exp_last_q.pop_front();
          check("beat_data", bus.out_data, d);
          check("beat_last", bus.out_last, l);
        end
        got_q.push_back(int'(bus.out_data));
        acc_cyc_q.push_back(cyc);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      if (eng_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (bus.req_valid && bus.req_ready) req_cyc = cyc;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_eng_clr"}, eng_clr, 0);
    check({tag, "_eng_on"}, eng_on, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_ovf"}, err_ovf, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // Loads the expected beats for a request of n terms ending at beat abort_at (-1: none).
  task automatic load_expect(input int n, inout int abort_at, output int nexp, output bit ovf);
    bit found;
    nexp  = n;
    ovf   = 1'b0;
    found = 1'b0;
`ifdef FIB_SEQ_OVF_CHK_EN
    for (int i = 2; i < n; i++) begin
      if (!found && (fib_term(i) < fib_term(i - 1))) begin
        nexp  = i;
        ovf   = 1'b1;
        found = 1'b1;
      end
    end
`endif
    if (abort_at >= 0 && abort_at < nexp) begin
      nexp = abort_at + 1;
      ovf  = 1'b0;
    end else begin
      abort_at = -1;
    end
    exp_q.delete();
    exp_last_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    for (int i = 0; i < nexp; i++) begin
      exp_q.push_back(W'(fib_term(i)));
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  // ready_pct < 0 selects the fixed ready pattern 1,0,0,1
  task automatic run_seq(input int n, input int ready_pct, input int abort_in, input bit stray);
    int  nexp, budget, base_done, base_clr, exp_done, abort_at;
    bit  ovf, aborted;
    abort_at = abort_in;
    wait_idle();
    load_expect(n, abort_at, nexp, ovf);
    base_done = done_cnt;
    base_clr  = clr_cnt;
    bus.req_valid = 1'b1;
    bus.req_count = CW'(n);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_count = CW'($urandom);
    check("err_clr_on_req", err_ovf, 0);
    aborted = 1'b0;
    budget  = 0;
    while (done_cnt == base_done && budget < 1000) begin
      if (ready_pct < 0) bus.out_ready = ((budget % 4) == 0) || ((budget % 4) == 3);
      else               bus.out_ready = ($urandom_range(0, 99) < ready_pct);
      abort = 1'b0;
      if (abort_at >= 0 && !aborted && bus.out_valid && got_q.size() == abort_at) begin
        abort = 1'b1;
        bus.out_ready = 1'b1;
        aborted = 1'b1;
      end
      if (stray && budget == 1) begin
        bus.req_valid = 1'b1;
        bus.req_count = 16'd3;
      end else begin
        bus.req_valid = 1'b0;
      end
      @(posedge clk); #1;
      budget++;
    end
    abort = 1'b0;
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b0;
    if (budget >= 1000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
    end
    check("clr_once", clr_cnt - base_clr, 1);
    check("clr_timing", clr_cyc, req_cyc + 1);
    check("beats_remaining", exp_q.size(), 0);
    if (nexp == 0)                  exp_done = clr_cyc + 1;
    else if (acc_cyc_q.size() > 0)  exp_done = acc_cyc_q[$] + (ovf ? 2 : 1);
    else                            exp_done = -1;
    check("done_timing", done_cyc, exp_done);
    check("err_ovf_end", err_ovf, ovf);
    check("idle_after_done", busy, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("done_single_pulse", done_cnt - base_done, 1);
    check("no_restart", clr_cnt - base_clr, 1);
    check("still_idle", busy, 0);
  endtask

  task automatic reset_mid_run();
    int nexp, abort_at, k;
    bit ovf;
    abort_at = -1;
    wait_idle();
    load_expect(10, abort_at, nexp, ovf);
    bus.req_valid = 1'b1;
    bus.req_count = 16'd10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (got_q.size() < 3 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_reach_beats", got_q.size() >= 3, 1);
    check("rst_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    exp_q.delete();
    exp_last_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    check_reset_vals("rst_hold");
    reset_n = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("rst_after");
  endtask

  int t1[5] = '{0, 1, 1, 2, 3};
  int t3[4] = '{0, 1, 1, 2};

  initial begin
    int base, n, ab;
    bit st;
    reset_n       = 1'b0;
    abort         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_count = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 5 terms, always ready
    run_seq(5, 100, -1, 1'b0);
    check("t1_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("t1_term", got_q[i], t1[i]);
    if (acc_cyc_q.size() > 0) check("t1_first_latency", acc_cyc_q[0] - req_cyc, 2);
    check("t1_done_cycle", done_cyc - req_cyc, 7);

    // zero-length request
    base = busy_cnt;
    run_seq(0, 100, -1, 1'b0);
    check("t2_no_beats", got_q.size(), 0);
    check("t2_done_cycle", done_cyc - req_cyc, 2);
    check("t2_busy_cycles", busy_cnt - base, 2);

    // back-pressure pattern
    run_seq(4, -1, -1, 1'b0);
    check("t3_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("t3_term", got_q[i], t3[i]);

    // abort on the second beat
    run_seq(10, 100, 1, 1'b0);
    check("t4_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t4_beat0", got_q[0], 0);
      check("t4_beat1", got_q[1], 1);
    end

    // abort while idle is ignored
    base = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done_cnt - base, 0);

    // 20 terms through an 8-bit engine
    run_seq(20, 100, -1, 1'b0);
`ifdef FIB_SEQ_OVF_CHK_EN
    check("t5_count", got_q.size(), 14);
    if (got_q.size() == 14) check("t5_last_term", got_q[13], 233);
    check("t5_err_ovf", err_ovf, 1);
`else
    check("t5_count", got_q.size(), 20);
    if (got_q.size() == 20) check("t5_wrapped_term", got_q[14], 121);
    check("t5_err_ovf", err_ovf, 0);
`endif
    run_seq(3, 100, -1, 1'b0);
    check("t5_err_cleared", err_ovf, 0);

    // request while busy is dropped, then reset mid-run
    run_seq(8, 100, -1, 1'b1);
    check("t6_count", got_q.size(), 8);
    reset_mid_run();
    run_seq(3, 100, -1, 1'b0);
    check("t6_recover_count", got_q.size(), 3);

    // randomized sequences
    repeat (25) begin
      n  = $urandom_range(0, 20);
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      st = (n > 0) && ($urandom_range(0, 1) == 1);
      run_seq(n, $urandom_range(40, 100), ab, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
